// File: rtl/gray_tracker.sv
// Gray-code position tracker: two-stage pipeline that decodes Gray samples, classifies the
// step against the previous sample and accumulates a signed position.
// Optional skip-error counter: define GRAY_TRACKER_ERRCNT_EN to add the err_cnt output.
module gray_tracker #(
  parameter int WIDTH = 3,
  parameter int POS_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        gray,
  input  logic                    pos_clr,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        bin,
  output logic                    step_up,
  output logic                    step_dn,
  output logic                    skip_err,
  output logic signed [POS_W-1:0] position
`ifdef GRAY_TRACKER_ERRCNT_EN
  ,
  output logic [7:0]              err_cnt
`endif
);

  typedef enum logic {INIT, TRACK} state_t;

  localparam logic [WIDTH-1:0]        D_ONE   = WIDTH'(1);
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0]        gray_p0_q;
  logic                    vld_p0_q;
  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        prev_q, prev_d;
  logic [WIDTH-1:0]        bin_q, bin_d;
  logic                    vld_p1_q;
  logic                    up_q, up_d;
  logic                    dn_q, dn_d;
  logic                    skip_q, skip_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic [WIDTH-1:0]        dec;
  logic [WIDTH-1:0]        delta;

  // Stage 1: capture the raw Gray sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_p0_q <= '0;
      vld_p0_q  <= 1'b0;
    end else begin
      vld_p0_q <= in_valid;
      if (in_valid) gray_p0_q <= gray;
    end
  end

  // Stage 2: decode, classify against prev, accumulate position
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    bin_d   = bin_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    skip_d  = 1'b0;
    pos_d   = pos_q;
    dec     = gray2bin(gray_p0_q);
    delta   = dec - prev_q;
    if (vld_p0_q) begin
      bin_d  = dec;
      prev_d = dec;
      case (state_q)
        INIT: state_d = TRACK;
        TRACK: begin
          if (delta == D_ONE) begin
            up_d  = 1'b1;
            pos_d = pos_q + POS_ONE;
          end else if (delta == '1) begin
            dn_d  = 1'b1;
            pos_d = pos_q - POS_ONE;
          end else if (delta != '0) begin
            skip_d = 1'b1;
          end
        end
        default: state_d = INIT;
      endcase
    end
    // Clearing wins over any step landing on the same edge
    if (pos_clr) pos_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      prev_q   <= '0;
      bin_q    <= '0;
      vld_p1_q <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      skip_q   <= 1'b0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      bin_q    <= bin_d;
      vld_p1_q <= vld_p0_q;
      up_q     <= up_d;
      dn_q     <= dn_d;
      skip_q   <= skip_d;
      pos_q    <= pos_d;
    end
  end

  assign out_valid = vld_p1_q;
  assign bin       = bin_q;
  assign step_up   = up_q;
  assign step_dn   = dn_q;
  assign skip_err  = skip_q;
  assign position  = pos_q;

`ifdef GRAY_TRACKER_ERRCNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (pos_clr)                      err_d = '0;
    else if (skip_d && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_gray_tracker.sv
// Directed + randomized bench for gray_tracker (WIDTH=3, POS_W=16) against a
// step-classification reference model kept in plain integer arithmetic.
module tb_gray_tracker;
  localparam int W    = 3;
  localparam int PW   = 16;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  gray = '0;
  logic          pos_clr = 1'b0;
  logic          out_valid;
  logic [W-1:0]  bin;
  logic          step_up, step_dn, skip_err;
  logic [PW-1:0] position;
`ifdef GRAY_TRACKER_ERRCNT_EN
  logic [7:0]    err_cnt;
`endif

  gray_tracker #(.WIDTH(W), .POS_W(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray(gray), .pos_clr(pos_clr),
    .out_valid(out_valid), .bin(bin), .step_up(step_up), .step_dn(step_dn),
    .skip_err(skip_err), .position(position)
`ifdef GRAY_TRACKER_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_s1v, m_have, m_ov, m_up, m_dn, m_sk;
  int m_s1g, m_prev, m_bin, m_pos, m_err;
  int lastb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input int g);
    int b = 0;
    for (int k = 0; k < W; k++) b ^= (g >> k);
    return b & MASK;
  endfunction

  task automatic model_reset();
    m_s1v = 0; m_s1g = 0; m_have = 0; m_prev = 0; m_bin = 0;
    m_ov = 0; m_up = 0; m_dn = 0; m_sk = 0; m_pos = 0; m_err = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    check({tag, ".step_up"},   32'(step_up),   32'(m_up));
    check({tag, ".step_dn"},   32'(step_dn),   32'(m_dn));
    check({tag, ".skip_err"},  32'(skip_err),  32'(m_sk));
    check({tag, ".bin"},       32'(bin),       32'(m_bin));
    check({tag, ".position"},  32'(position),  32'(m_pos));
`ifdef GRAY_TRACKER_ERRCNT_EN
    check({tag, ".err_cnt"},   32'(err_cnt),   32'(m_err));
`endif
  endtask

  // One clock: drive inputs, advance the model by one edge, compare
  task automatic cyc(input bit v, input int g, input bit clr, input string tag);
    int b, d;
    in_valid = v; gray = W'(g); pos_clr = clr;
    @(posedge clk); #1;
    m_up = 0; m_dn = 0; m_sk = 0; m_ov = m_s1v;
    if (m_s1v) begin
      b = decode(m_s1g);
      m_bin = b;
      if (m_have) begin
        d = (b - m_prev) & MASK;
        if (d == 1)         begin m_up = 1; m_pos = m_pos + 1; end
        else if (d == MASK) begin m_dn = 1; m_pos = m_pos - 1; end
        else if (d != 0)    m_sk = 1;
      end
      m_have = 1;
      m_prev = b;
    end
    if (clr) begin m_pos = 0; m_err = 0; end
    else if (m_sk && m_err < 255) m_err++;
    m_pos = m_pos & ((1 << PW) - 1);
    m_s1v = v;
    if (v) m_s1g = g;
    in_valid = 1'b0; pos_clr = 1'b0;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; #1;
    model_reset();
    compare_all(tag);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    // Up sequence 0,1,2,3; first result two edges after first sample
    cyc(1, 3'b000, 0, "up0");
    check("up.latency_not_early", 32'(out_valid), 32'd0);
    cyc(1, 3'b001, 0, "up1");
    check("up.first_valid", 32'(out_valid), 32'd1);
    cyc(1, 3'b011, 0, "up2");
    cyc(1, 3'b010, 0, "up3");
    cyc(0, 0, 0, "up_d0");
    cyc(0, 0, 0, "up_d1");
    check("up.position3", 32'(position), 32'd3);
    check("up.bin3", 32'(bin), 32'd3);

    // Climb to 6, then wrap 7 -> 0 up, then 0 -> 7 down
    cyc(1, 3'b110, 0, "to4");
    cyc(1, 3'b111, 0, "to5");
    cyc(1, 3'b101, 0, "to6");
    cyc(1, 3'b100, 0, "wrap7");
    cyc(1, 3'b000, 0, "wrap0");
    cyc(1, 3'b100, 0, "back7");
    cyc(0, 0, 0, "wrap_d0");
    cyc(0, 0, 0, "wrap_d1");
    check("wrap.position7", 32'(position), 32'd7);
    check("wrap.stepdn_gone", 32'(step_dn), 32'd0);

    // Clear coinciding with a step result, then a following step
    cyc(1, 3'b000, 0, "clr_s");
    cyc(0, 0, 1, "clr_hit");
    check("clr.position0", 32'(position), 32'd0);
    check("clr.step_up", 32'(step_up), 32'd1);
    cyc(1, 3'b001, 0, "clr_n");
    cyc(0, 0, 0, "clr_n1");
    check("clr.position1", 32'(position), 32'd1);

    // Down from zero
    do_reset("reset2");
    cyc(1, 3'b000, 0, "dn0");
    cyc(1, 3'b100, 0, "dn7");
    cyc(0, 0, 0, "dn_d0");
    check("dn.position_ffff", 32'(position), 32'h0000FFFF);
    check("dn.step_dn", 32'(step_dn), 32'd1);

    // Skip then recover
    do_reset("reset3");
    cyc(1, 3'b000, 0, "sk0");
    cyc(1, 3'b011, 0, "sk2");
    cyc(1, 3'b010, 0, "sk3");
    check("skip.flag", 32'(skip_err), 32'd1);
    check("skip.position0", 32'(position), 32'd0);
    cyc(0, 0, 0, "sk_d0");
    check("skip.recover_up", 32'(step_up), 32'd1);
`ifdef GRAY_TRACKER_ERRCNT_EN
    check("skip.err_cnt1", 32'(err_cnt), 32'd1);
`endif

    // Reset between in-flight samples discards them
    cyc(1, 3'b001, 0, "fl_a");
    rst = 1'b1; #2; rst = 1'b0; model_reset();
    cyc(1, 3'b011, 0, "fl_b");
    rst = 1'b1; #2; rst = 1'b0; model_reset();
    cyc(0, 0, 0, "fl_d0");
    cyc(0, 0, 0, "fl_d1");
    check("flush.no_valid", 32'(out_valid), 32'd0);
    cyc(1, 3'b110, 0, "fl_c");
    cyc(0, 0, 0, "fl_c1");
    check("flush.init_valid", 32'(out_valid), 32'd1);
    check("flush.init_noflag", 32'({step_up, step_dn, skip_err}), 32'd0);
    check("flush.init_bin", 32'(bin), 32'd4);

    // Randomized traffic, mostly small moves
    lastb = 4;
    for (int i = 0; i < 400; i++) begin
      int r, b;
      bit v;
      r = int'($urandom_range(0, 9));
      if (r < 4)      b = (lastb + 1) & MASK;
      else if (r < 7) b = (lastb - 1) & MASK;
      else if (r < 8) b = lastb;
      else            b = int'($urandom_range(0, MASK));
      v = ($urandom_range(0, 3) != 0);
      if (v) lastb = b;
      cyc(v, b ^ (b >> 1), ($urandom_range(0, 24) == 0), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
